fetch_sequencer: RTL and testbench

- Owns the architectural PC register and sequences instruction-memory fetches through a single-outstanding req/ack handshake.
- Presents one buffered instruction to decode with a valid/stall handshake.
- Applies redirects (branch/jump/jr/exception/eret target, already resolved by the next-PC logic) so that stale fetches are discarded.
- Sits between the next-PC logic, instruction memory and the decode stage.

---
 rtl/fetch_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Owns the architectural PC and sequences instruction fetches through a
// single-outstanding req/ack memory handshake. One fetched instruction is
// buffered and offered to decode with a valid/stall handshake. Redirects from
// the next-PC logic overwrite the PC and guarantee that no instruction fetched
// before the redirect is ever presented to decode.
//
// Optional feature (compile-time macro FETCH_TIMEOUT_EN):
//   When defined, a 16-bit wait counter raises a sticky o_fetch_err once a
//   request has gone TIMEOUT cycles without an acknowledge. When undefined,
//   o_fetch_err is tied to 0.
//
// Parameters:
//   RESET_PC  PC loaded on reset (word aligned)
//   TIMEOUT   un-acked request cycles before o_fetch_err (FETCH_TIMEOUT_EN only)
//
// Ports:
//   i_clk             clock, all state updates on the rising edge
//   i_rst_n           asynchronous active-low reset
//   o_imem_req        fetch request (registered)
//   o_imem_addr       fetch address (word aligned)
//   i_imem_ack        memory completes the current request this cycle
//   i_imem_rdata      instruction word, valid with i_imem_ack
//   o_inst_valid      buffered instruction available to decode
//   o_inst            buffered instruction word
//   o_inst_pc         address of the buffered instruction
//   i_stall           decode cannot accept this cycle
//   i_redirect_valid  one-cycle redirect request
//   i_redirect_pc     redirect target (bits [1:0] forced to 0)
//   o_fetch_err       sticky fetch timeout flag
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_fetch_err
);

    // Elaboration-time parameter sanity checks.
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("fetch_sequencer: RESET_PC must be word aligned");
    end
    if (TIMEOUT == 0 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("fetch_sequencer: TIMEOUT must be in 1..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_drain_addr;
    logic        r_req;
    logic        r_valid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;

    logic [31:0] w_redirect_pc;
    logic [31:0] w_pc_inc;

    assign w_redirect_pc = i_redirect_pc & ~32'h0000_0003;
    assign w_pc_inc      = r_pc + 32'd4;   // natural 32-bit wrap: FFFF_FFFC -> 0

    // While draining, the PC already holds the newer redirect target, but the
    // memory still owns the old un-acked request; the address it was issued
    // with is kept stable on the bus until that ack arrives.
    assign o_imem_addr  = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
    assign o_imem_req   = r_req;
    assign o_inst_valid = r_valid;
    assign o_inst       = r_inst;
    assign o_inst_pc    = r_inst_pc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_drain_addr <= RESET_PC;
            r_req        <= 1'b0;
            r_valid      <= 1'b0;
            r_inst       <= 32'd0;
            r_inst_pc    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req   <= 1'b1;
                    r_state <= S_REQ;
                    if (i_redirect_valid) begin
                        r_pc <= w_redirect_pc;
                    end
                end

                S_REQ: begin
                    if (i_redirect_valid) begin
                        r_pc  <= w_redirect_pc;
                        r_req <= 1'b1;
                        if (i_imem_ack) begin
                            // Acked data belongs to the old path: drop it and
                            // issue the new address straight away.
                            r_state <= S_REQ;
                        end else begin
                            // Request cannot be withdrawn; remember its address
                            // and wait for the ack before moving on.
                            r_drain_addr <= r_pc;
                            r_state      <= S_DRAIN;
                        end
                    end else if (i_imem_ack) begin
                        r_inst    <= i_imem_rdata;
                        r_inst_pc <= r_pc;
                        r_pc      <= w_pc_inc;
                        r_valid   <= 1'b1;
                        r_req     <= 1'b0;
                        r_state   <= S_VALID;
                    end
                end

                S_VALID: begin
                    if (i_redirect_valid) begin
                        // Buffered instruction is killed, never accepted.
                        r_pc    <= w_redirect_pc;
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end else if (!i_stall) begin
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end

                S_DRAIN: begin
                    if (i_redirect_valid) begin
                        r_pc <= w_redirect_pc;
                    end
                    if (i_imem_ack) begin
                        // Discarded data; r_req stays high for the new target.
                        r_state <= S_REQ;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    logic [15:0] r_wait_cnt;
    logic        r_fetch_err;
    logic [15:0] w_wait_cnt_next;

    // Counts consecutive cycles of an outstanding, un-acked request.
    always_comb begin
        w_wait_cnt_next = 16'd0;
        if (r_req && !i_imem_ack) begin
            w_wait_cnt_next = (r_wait_cnt == 16'hFFFF) ? r_wait_cnt : r_wait_cnt + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt  <= 16'd0;
            r_fetch_err <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_cnt_next;
            if (w_wait_cnt_next >= TIMEOUT_CNT) begin
                r_fetch_err <= 1'b1;
            end
        end
    end

    assign o_fetch_err = r_fetch_err;
`else
    assign o_fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed bench for fetch_sequencer. A small memory responder acks requests
// after a programmable latency and returns a word derived from the address.
// A behavioural model tracks the PC of the next instruction decode must see,
// the request/handshake rules and the timeout flag; it is compared against the
// DUT every cycle, alongside hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_PC (RESET_PC),
        .TIMEOUT  (16)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_imem_req       (imem_req),
        .o_imem_addr      (imem_addr),
        .i_imem_ack       (imem_ack),
        .i_imem_rdata     (imem_rdata),
        .o_inst_valid     (inst_valid),
        .o_inst           (inst),
        .o_inst_pc        (inst_pc),
        .i_stall          (stall),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_fetch_err      (fetch_err)
    );

    int errors = 0;
    int checks = 0;

    // memory responder state
    int lat     = 0;
    int wcnt    = 0;
    bit mem_prev_req = 1'b0;

    // behavioural model state
    logic [31:0] m_pc = RESET_PC;   // PC of next instruction decode must see
    logic        m_err = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
    int          m_cnt = 0;
`endif
    bit          p_req = 1'b0;
    bit          p_ack = 1'b0;
    bit          p_hold = 1'b0;
    bit          p_accept = 1'b0;
    logic [31:0] p_addr = 32'd0;
    logic [31:0] p_inst = 32'd0;
    logic [31:0] p_inst_pc = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h2408_0001;
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, then advance the model using the
    // inputs the DUT will sample on the coming rising edge.
    task automatic check_cycle();
        bit accept;
        if (!rst_n) begin
            m_pc  = RESET_PC;
            m_err = 1'b0;
`ifdef FETCH_TIMEOUT_EN
            m_cnt = 0;
`endif
            p_req = 0; p_ack = 0; p_hold = 0; p_accept = 0;
            chk1("err_in_reset", fetch_err, m_err);
            return;
        end
        if (imem_req && (!p_req || p_ack))
            chk("req_start_addr", imem_addr, m_pc);
        if (p_req && !p_ack) begin
            chk1("req_held_until_ack", imem_req, 1'b1);
            chk("addr_stable", imem_addr, p_addr);
        end
        if (inst_valid) begin
            chk("inst_pc_model", inst_pc, m_pc);
            chk("inst_data_model", inst, mem_word(inst_pc));
            chk1("no_req_while_valid", imem_req, 1'b0);
        end
        if (p_hold) begin
            chk1("stall_hold_valid", inst_valid, 1'b1);
            chk("stall_hold_inst", inst, p_inst);
            chk("stall_hold_pc", inst_pc, p_inst_pc);
        end
        if (p_accept)
            chk1("max_rate_one_per_two", inst_valid, 1'b0);
        chk1("fetch_err_model", fetch_err, m_err);

        accept = inst_valid && !stall && !redirect_valid;
        if (redirect_valid)  m_pc = redirect_pc & ~32'h3;
        else if (accept)     m_pc = m_pc + 32'd4;
`ifdef FETCH_TIMEOUT_EN
        if (imem_req && !imem_ack) begin
            if (m_cnt < 65535) m_cnt++;
        end else begin
            m_cnt = 0;
        end
        if (m_cnt >= TB_TIMEOUT) m_err = 1'b1;
`endif
        p_req     = imem_req;
        p_ack     = imem_ack;
        p_addr    = imem_addr;
        p_hold    = inst_valid && stall && !redirect_valid;
        p_accept  = accept;
        p_inst    = inst;
        p_inst_pc = inst_pc;
    endtask

    // Memory: acks a request once it has waited 'lat' cycles.
    task automatic mem_update();
        if (!rst_n) begin
            wcnt = 0;
            imem_ack = 1'b0;
            imem_rdata = 32'd0;
            mem_prev_req = 1'b0;
            return;
        end
        if (imem_ack || !mem_prev_req) wcnt = 0;
        else                           wcnt++;
        imem_ack   = imem_req && (wcnt >= lat);
        imem_rdata = imem_ack ? mem_word(imem_addr) : 32'd0;
        mem_prev_req = imem_req;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        mem_update();
    endtask

    task automatic wait_valid(input string name, input int max_cycles);
        bit found = 1'b0;
        for (int i = 0; i < max_cycles && !found; i++) begin
            tick();
            found = inst_valid;
        end
        chk1(name, found, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        imem_ack = 1'b0;
        imem_rdata = 32'd0;

        repeat (3) tick();
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk1("rst_err", fetch_err, 1'b0);
        chk("rst_addr", imem_addr, RESET_PC);

        // first fetch after reset release
        rst_n = 1'b1;
        tick();
        chk1("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, 32'hBFC0_0000);
        tick();
        chk1("first_valid", inst_valid, 1'b1);
        chk("first_inst", inst, 32'h2408_0001);
        chk("first_inst_pc", inst_pc, 32'hBFC0_0000);
        chk1("first_req_low", imem_req, 1'b0);

        // streaming at one instruction per two cycles
        tick();
        chk1("stream_gap_valid", inst_valid, 1'b0);
        chk("stream_req_addr", imem_addr, 32'hBFC0_0004);
        tick();
        chk("stream_pc1", inst_pc, 32'hBFC0_0004);
        tick();
        tick();
        chk1("stream_valid2", inst_valid, 1'b1);
        chk("stream_pc2", inst_pc, 32'hBFC0_0008);

        // stall for five cycles
        stall = 1'b1;
        repeat (5) tick();
        chk1("stall_valid", inst_valid, 1'b1);
        chk("stall_pc", inst_pc, 32'hBFC0_0008);
        chk1("stall_req", imem_req, 1'b0);
        lat = 3;
        stall = 1'b0;
        tick();
        chk1("after_stall_req", imem_req, 1'b1);
        chk("after_stall_addr", imem_addr, 32'hBFC0_000C);

        // reset in the middle of an outstanding request
        tick();
        rst_n = 1'b0;
        tick();
        chk1("midrst_req", imem_req, 1'b0);
        chk1("midrst_valid", inst_valid, 1'b0);
        rst_n = 1'b1;
        lat = 0;
        tick();
        chk("postrst_addr", imem_addr, RESET_PC);
        tick();
        chk("postrst_inst_pc", inst_pc, 32'hBFC0_0000);

        // redirect under an un-acked request: drain, then refetch target
        lat = 3;
        tick();
        chk("drain_req_addr", imem_addr, 32'hBFC0_0004);
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0083;
        tick();
        redirect_valid = 1'b0;
        chk1("drain_req", imem_req, 1'b1);
        chk("drain_addr_held", imem_addr, 32'hBFC0_0004);
        tick();
        tick();
        tick();
        chk1("drain_no_valid", inst_valid, 1'b0);
        chk("drain_new_addr", imem_addr, 32'h8000_0080);
        lat = 0;
        wait_valid("drain_wait_valid", 8);
        chk("drain_inst_pc", inst_pc, 32'h8000_0080);
        chk("drain_inst", inst, 32'h8000_0080 ^ 32'h5A5A_0F0F);

        // redirect in the same cycle as an ack
        tick();
        chk("ackred_req_addr", imem_addr, 32'h8000_0084);
        chk1("ackred_ack", imem_ack, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_0000;
        tick();
        redirect_valid = 1'b0;
        chk1("ackred_no_valid", inst_valid, 1'b0);
        chk1("ackred_req", imem_req, 1'b1);
        chk("ackred_addr", imem_addr, 32'h0040_0000);
        tick();
        chk("ackred_inst_pc", inst_pc, 32'h0040_0000);

        // redirect while an instruction is offered: it is dropped
        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_0100;
        tick();
        redirect_valid = 1'b0;
        chk1("kill_valid", inst_valid, 1'b0);
        chk("kill_addr", imem_addr, 32'h0040_0100);
        wait_valid("kill_wait_valid", 6);
        chk("kill_inst_pc", inst_pc, 32'h0040_0100);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        wait_valid("wrap_wait_valid", 6);
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        tick();

        // long ack latency: timeout flag behaviour
        lat = 40;
        tick();
        chk1("to_req", imem_req, 1'b1);
        repeat (15) tick();
        chk1("to_err_before", fetch_err, 1'b0);
        tick();
`ifdef FETCH_TIMEOUT_EN
        chk1("to_err_set", fetch_err, 1'b1);
`else
        chk1("to_err_set", fetch_err, 1'b0);
`endif
        lat = 0;
        tick();
        tick();
        tick();
`ifdef FETCH_TIMEOUT_EN
        chk1("to_err_sticky", fetch_err, 1'b1);
`else
        chk1("to_err_sticky", fetch_err, 1'b0);
`endif
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
